formacao_inimigos: RTL and testbench
====================================

// Module: formacao_inimigos
// PURPOSE
//  Parametrised enemy-formation motion controller for the Space Invaders top level. It owns one formation origin;
//  the renderer derives each enemy's position from it. It also provides step timing, direction reversal at the
//  screen bounds, speed-up per descent, invasion detection and the all-killed flag. It takes the alive mask from
//  the enemy instances. Bounds use only the extreme alive columns and the lowest alive row.
// PARAMETERS
//  LINHAS        4        formation rows
//  COLUNAS       10       formation columns
//  DIST_COLUNAS  30       column pitch (px)
//  DIST_LINHAS   30       row pitch (px)
//  DESLOC        10       extra X offset for odd rows (stagger)
//  LARGURA       20       enemy sprite width (px)
//  ALTURA        20       enemy sprite height (px)
//  X_INICIAL     150      origin X after reset/restart
//  Y_INICIAL     40       origin Y after reset/restart
//  X_MIN         150      leftmost allowed left edge
//  X_MAX         760      rightmost allowed right edge
//  Y_LIMITE      440      bottom line; reaching it = invasion
//  DELTA_X       1        base horizontal step (px)
//  DELTA_Y       50       descent per reversal (px)
//  MAX_NIVEL     15       speed level saturation value
//  PERIODO       2097152  clk cycles per movement step (>=2)
// PORTS
//  clk        in   1          system clock
//  reset      in   1          asynchronous, active-low reset
//  enable     in   1          1 = game running (estado==1); 0 freezes step counter and motion
//  restart    in   1          synchronous reload of initial formation; priority over enable
//  vivo       in   LINHAS*COLUNAS  alive mask; bit r*COLUNAS+c = row r, column c
//  org_x      out  11         formation origin X; enemy(r,c) X = org_x + c*DIST_COLUNAS + (r odd ? DESLOC : 0)
//  org_y      out  11         formation origin Y; enemy(r,c) Y = org_y + r*DIST_LINHAS
//  direcao    out  1          0 = right, 1 = left
//  nivel      out  5          current speed level; horizontal step = DELTA_X + nivel
//  passo      out  1          one-cycle pulse on every step tick where motion was evaluated
//  invadiu    out  1          sticky: lowest alive row reached Y_LIMITE
//  limpo      out  1          registered: vivo == 0
// BEHAVIOUR
//  Reset (async, reset=0) gives these values:
//   - org_x=X_INICIAL, org_y=Y_INICIAL, direcao=0, nivel=0
//   - passo=0, invadiu=0, limpo=0
//   - step counter=0, state=MOVE_H
//  States: MOVE_H, MOVE_V, PARADO.
//  Step tick: the counter counts 0..PERIODO-1 only while enable=1 and state!=PARADO.
//   - Tick fires on the cycle after the counter hits PERIODO-1; the counter then wraps to 0.
//   - passo=1 for exactly that one cycle.
//  Bounds, combinational from vivo (column alive = OR over rows; row alive = OR over columns):
//   - esq = org_x + cmin*DIST_COLUNAS
//   - dir = org_x + cmax*DIST_COLUNAS + DESLOC(if LINHAS>1) + LARGURA
//   - base = org_y + rmax*DIST_LINHAS + ALTURA
//   - All arithmetic is 12-bit unsigned to avoid wrap; org_x/org_y never go below 0.
//  MOVE_H on tick, with spd = DELTA_X + nivel:
//   - direcao=0: if dir+spd <= X_MAX then org_x += spd; else direcao<=1 and go to MOVE_V with no X move.
//   - direcao=1: if esq >= X_MIN+spd then org_x -= spd; else direcao<=0 and go to MOVE_V.
//  MOVE_V on tick:
//   - org_y += DELTA_Y; nivel = min(nivel+1, MAX_NIVEL).
//   - If base+DELTA_Y >= Y_LIMITE: invadiu<=1 and go to PARADO; else go to MOVE_H.
//  limpo: limpo<=1 one cycle after vivo==0 is sampled; the state goes to PARADO in that same cycle, with no
//   further ticks.
//  Simultaneous events: vivo going to 0 on a tick cycle means the tick is ignored, limpo is set and the state
//   goes to PARADO.
//  PARADO: all outputs hold; only restart or reset leaves it.
//  restart=1: same values as reset, applied at the clock edge; overrides any tick in that cycle.
//  enable=0 mid-period: the counter holds its value and resumes when enable returns; passo stays 0.
// TESTING
//  1. PERIODO=4, all alive, release reset, enable=1 -> passo on cycles 4,8,12...; org_x 151,152,153; org_y=40.
//  2. Only column 0 alive -> org_x climbs to 730 (dir=760). Next tick: direcao=1, org_x stays. Next tick:
//     org_y=90, nivel=1. Next tick: org_x=728.
//  3. All alive, direcao=1, org_x=151, nivel=1 -> tick gives reversal (151 < 150+2), direcao=0, then descent.
//  4. All rows alive, force repeated reversals -> after 6th descent org_y=340, invadiu=1, PARADO, no more
//     passo. With only row 0 alive: invasion at org_y=440.
//  5. Clear vivo to 0 mid-move -> limpo=1 the next cycle, org_x frozen. Pulse restart -> org 150/40,
//     limpo=0, invadiu=0.
//  6. Assert reset=0 between clock edges with nivel=3, org_y=190 -> outputs reach reset values at once,
//     without waiting for clk.

Source files
------------

// File: rtl/formacao_inimigos.sv
// Enemy-formation motion controller: owns the formation origin, step timing, edge reversal,
// per-descent speed-up, invasion detection and the all-killed flag.
module formacao_inimigos #(
    parameter int LINHAS       = 4,
    parameter int COLUNAS      = 10,
    parameter int DIST_COLUNAS = 30,
    parameter int DIST_LINHAS  = 30,
    parameter int DESLOC       = 10,
    parameter int LARGURA      = 20,
    parameter int ALTURA       = 20,
    parameter int X_INICIAL    = 150,
    parameter int Y_INICIAL    = 40,
    parameter int X_MIN        = 150,
    parameter int X_MAX        = 760,
    parameter int Y_LIMITE     = 440,
    parameter int DELTA_X      = 1,
    parameter int DELTA_Y      = 50,
    parameter int MAX_NIVEL    = 15,
    parameter int PERIODO      = 2097152
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      restart,
    input  logic [LINHAS*COLUNAS-1:0] vivo,
    output logic [10:0]               org_x,
    output logic [10:0]               org_y,
    output logic                      direcao,
    output logic [4:0]                nivel,
    output logic                      passo,
    output logic                      invadiu,
    output logic                      limpo
);
    localparam int               CNT_W      = $clog2(PERIODO);
    localparam logic [CNT_W-1:0] CNT_TOPO   = CNT_W'(PERIODO - 1);
    localparam logic [11:0]      DESLOC_DIR = (LINHAS > 1) ? 12'(DESLOC) : 12'd0;

    typedef enum logic [1:0] {MOVE_H, MOVE_V, PARADO} estado_t;

    estado_t            estado;
    logic [CNT_W-1:0]   cnt;
    logic [COLUNAS-1:0] col_viva;
    logic [LINHAS-1:0]  lin_viva;
    logic [11:0]        cmin, cmax, rmax;
    logic [11:0]        esq, dir, base, spd;
    logic               tick;

    function automatic logic [10:0] sub_sat(input logic [11:0] a, input logic [11:0] b);
        return (a < b) ? 11'd0 : 11'(a - b);
    endfunction

    function automatic logic [4:0] nivel_inc(input logic [4:0] n);
        return (n >= 5'(MAX_NIVEL)) ? 5'(MAX_NIVEL) : n + 5'd1;
    endfunction

    // Only the extreme alive columns and the lowest alive row bound the formation
    always_comb begin
        col_viva = '0;
        lin_viva = '0;
        for (int r = 0; r < LINHAS; r++) begin
            for (int c = 0; c < COLUNAS; c++) begin
                if (vivo[r*COLUNAS + c]) begin
                    col_viva[c] = 1'b1;
                    lin_viva[r] = 1'b1;
                end
            end
        end
        cmin = '0;
        cmax = '0;
        rmax = '0;
        for (int c = COLUNAS - 1; c >= 0; c--) begin
            if (col_viva[c]) cmin = 12'(c);
        end
        for (int c = 0; c < COLUNAS; c++) begin
            if (col_viva[c]) cmax = 12'(c);
        end
        for (int r = 0; r < LINHAS; r++) begin
            if (lin_viva[r]) rmax = 12'(r);
        end
    end

    assign esq  = {1'b0, org_x} + cmin * 12'(DIST_COLUNAS);
    assign dir  = {1'b0, org_x} + cmax * 12'(DIST_COLUNAS) + DESLOC_DIR + 12'(LARGURA);
    assign base = {1'b0, org_y} + rmax * 12'(DIST_LINHAS) + 12'(ALTURA);
    assign spd  = 12'(DELTA_X) + {7'd0, nivel};
    assign tick = enable && (cnt == CNT_TOPO);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            org_x   <= 11'(X_INICIAL);
            org_y   <= 11'(Y_INICIAL);
            direcao <= 1'b0;
            nivel   <= 5'd0;
            passo   <= 1'b0;
            invadiu <= 1'b0;
            limpo   <= 1'b0;
            cnt     <= '0;
            estado  <= MOVE_H;
        end else if (restart) begin
            org_x   <= 11'(X_INICIAL);
            org_y   <= 11'(Y_INICIAL);
            direcao <= 1'b0;
            nivel   <= 5'd0;
            passo   <= 1'b0;
            invadiu <= 1'b0;
            limpo   <= 1'b0;
            cnt     <= '0;
            estado  <= MOVE_H;
        end else begin
            passo <= 1'b0;
            if (estado != PARADO) begin
                // An empty formation wins over a coincident tick
                if (vivo == '0) begin
                    limpo  <= 1'b1;
                    estado <= PARADO;
                end else if (enable && !tick) begin
                    cnt <= cnt + 1'b1;
                end else if (tick) begin
                    cnt   <= '0;
                    passo <= 1'b1;
                    if (estado == MOVE_H) begin
                        if (!direcao) begin
                            if (dir + spd <= 12'(X_MAX)) begin
                                org_x <= 11'({1'b0, org_x} + spd);
                            end else begin
                                direcao <= 1'b1;
                                estado  <= MOVE_V;
                            end
                        end else begin
                            if (esq >= 12'(X_MIN) + spd) begin
                                org_x <= sub_sat({1'b0, org_x}, spd);
                            end else begin
                                direcao <= 1'b0;
                                estado  <= MOVE_V;
                            end
                        end
                    end else begin
                        org_y <= 11'({1'b0, org_y} + 12'(DELTA_Y));
                        nivel <= nivel_inc(nivel);
                        if (base + 12'(DELTA_Y) >= 12'(Y_LIMITE)) begin
                            invadiu <= 1'b1;
                            estado  <= PARADO;
                        end else begin
                            estado <= MOVE_H;
                        end
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_formacao_inimigos.sv
// Scoreboard bench for formacao_inimigos: a geometric model of the formation predicts every
// step result into a queue, and a monitor compares it whenever passo is presented.
`timescale 1ns/1ps
module tb_formacao_inimigos;
    localparam int COL = 10;
    localparam int LIN = 4;
    localparam int PER = 4;
    localparam logic [39:0] ALL  = 40'hFF_FFFF_FFFF;
    localparam logic [39:0] ROW0 = 40'h00_0000_03FF;
    localparam logic [39:0] COL0 = 40'h00_4010_0401;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        restart = 1'b0;
    logic [39:0] vivo = ALL;
    logic [10:0] org_x, org_y;
    logic        direcao;
    logic [4:0]  nivel;
    logic        passo, invadiu, limpo;

    int checks = 0;
    int failures = 0;

    typedef struct {
        int x;
        int y;
        bit dir;
        int nivel;
        bit inv;
    } exp_t;
    exp_t q[$];

    // Reference model state (spec-level: origin, direction, pending descent, stop flag)
    int m_x, m_y, m_nivel, m_cnt;
    bit m_dir, m_desce, m_inv, m_limpo, m_stop;

    formacao_inimigos #(.PERIODO(PER)) dut (
        .clk(clk), .reset(reset), .enable(enable), .restart(restart), .vivo(vivo),
        .org_x(org_x), .org_y(org_y), .direcao(direcao), .nivel(nivel),
        .passo(passo), .invadiu(invadiu), .limpo(limpo)
    );

    always #5 clk = ~clk;

    function automatic void chk(string name, int act, int expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, expv);
        end
    endfunction

    function automatic void model_reset();
        m_x = 150; m_y = 40; m_nivel = 0; m_cnt = 0;
        m_dir = 0; m_desce = 0; m_inv = 0; m_limpo = 0; m_stop = 0;
    endfunction

    function automatic void model_step();
        int spd, left, right, bot, ex, ey;
        spd = 1 + m_nivel;
        left = 100000; right = -1; bot = -1;
        for (int r = 0; r < LIN; r++) begin
            for (int c = 0; c < COL; c++) begin
                if (vivo[r*COL + c]) begin
                    ex = m_x + c*30;
                    ey = m_y + r*30 + 20;
                    if (ex < left) left = ex;
                    if (ex + 10 + 20 > right) right = ex + 10 + 20;
                    if (ey > bot) bot = ey;
                end
            end
        end
        if (!m_desce) begin
            if (!m_dir) begin
                if (right + spd <= 760) m_x = m_x + spd;
                else begin m_dir = 1; m_desce = 1; end
            end else begin
                if (left >= 150 + spd) m_x = (m_x >= spd) ? m_x - spd : 0;
                else begin m_dir = 0; m_desce = 1; end
            end
        end else begin
            m_y = m_y + 50;
            if (m_nivel < 15) m_nivel++;
            if (bot + 50 >= 440) begin m_inv = 1; m_stop = 1; end
            else m_desce = 0;
        end
    endfunction

    // Predicts what the coming clock edge does with the inputs just driven
    task automatic model_edge();
        if (restart) begin model_reset(); return; end
        if (m_stop) return;
        if (vivo == '0) begin m_limpo = 1; m_stop = 1; return; end
        if (!enable) return;
        m_cnt++;
        if (m_cnt < PER) return;
        m_cnt = 0;
        model_step();
        q.push_back('{m_x, m_y, m_dir, m_nivel, m_inv});
    endtask

    task automatic set_and_step(input bit en, input logic [39:0] v, input bit rs);
        enable = en;
        vivo = v;
        restart = rs;
        model_edge();
    endtask

    task automatic cycle(input bit en, input logic [39:0] v, input bit rs);
        @(negedge clk);
        set_and_step(en, v, rs);
    endtask

    task automatic chk_reset_vals(string tag);
        chk({tag, "_org_x"}, int'(org_x), 150);
        chk({tag, "_org_y"}, int'(org_y), 40);
        chk({tag, "_direcao"}, int'(direcao), 0);
        chk({tag, "_nivel"}, int'(nivel), 0);
        chk({tag, "_passo"}, int'(passo), 0);
        chk({tag, "_invadiu"}, int'(invadiu), 0);
        chk({tag, "_limpo"}, int'(limpo), 0);
    endtask

    // Monitor: a step result is owed exactly when the queue holds one
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                if (q.size() == 0) begin
                    if (passo) chk("passo_unexpected", int'(passo), 0);
                end else begin
                    e = q.pop_front();
                    chk("passo", int'(passo), 1);
                    chk("step_org_x", int'(org_x), e.x);
                    chk("step_org_y", int'(org_y), e.y);
                    chk("step_direcao", int'(direcao), int'(e.dir));
                    chk("step_nivel", int'(nivel), e.nivel);
                    chk("step_invadiu", int'(invadiu), int'(e.inv));
                end
                chk("limpo", int'(limpo), int'(m_limpo));
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "simulation time limit exceeded");
    end

    initial begin : stim
        logic [39:0] rv;
        int saved_x, k;
        model_reset();
        #1 reset = 1'b0;
        #11;
        chk_reset_vals("reset");

        @(negedge clk);
        reset = 1'b1;
        set_and_step(1, ALL, 0);

        // All alive with random enable gaps, until the invasion
        for (int i = 0; i < 12000 && !m_stop; i++) cycle($urandom_range(0, 9) < 8, ALL, 0);
        repeat (20) cycle(1, ALL, 0);
        chk("all_rows_inv_org_y", int'(org_y), 340);
        chk("all_rows_invadiu", int'(invadiu), 1);

        // Only row 0 alive: invasion happens lower
        cycle(1, ROW0, 1);
        for (int i = 0; i < 12000 && !m_stop; i++) cycle(1, ROW0, 0);
        repeat (20) cycle(1, ROW0, 0);
        chk("row0_inv_org_y", int'(org_y), 440);
        chk("row0_invadiu", int'(invadiu), 1);

        // Only column 0 alive until nivel 3, then asynchronous reset between edges
        cycle(1, COL0, 1);
        for (int i = 0; i < 12000 && m_nivel < 3; i++) cycle(1, COL0, 0);
        @(posedge clk);
        #2;
        chk("pre_async_org_y", int'(org_y), 190);
        chk("pre_async_nivel", int'(nivel), 3);
        reset = 1'b0;
        #1;
        chk_reset_vals("async");
        model_reset();
        q.delete();
        @(negedge clk);
        reset = 1'b1;
        set_and_step(1, ALL, 0);

        // Formation cleared mid-move, then restart
        repeat (30) cycle(1, ALL, 0);
        cycle(1, '0, 0);
        @(posedge clk);
        #2;
        chk("clear_limpo", int'(limpo), 1);
        saved_x = int'(org_x);
        repeat (12) cycle(1, ALL, 0);
        chk("clear_frozen_x", int'(org_x), saved_x);
        cycle(1, ALL, 1);
        cycle(1, ALL, 0);
        chk("restart_org_x", int'(org_x), 150);
        chk("restart_org_y", int'(org_y), 40);
        chk("restart_limpo", int'(limpo), 0);
        chk("restart_invadiu", int'(invadiu), 0);

        // Random masks, kills, enable gaps and occasional restarts
        for (int round = 0; round < 3; round++) begin
            rv = {8'($urandom), $urandom};
            if (rv == '0) rv = 40'd1;
            cycle(1, rv, 1);
            for (int i = 0; i < 3000 && !m_stop; i++) begin
                if ($urandom_range(0, 99) < 2) begin
                    k = $urandom_range(0, 39);
                    if ((rv & ~(40'd1 << k)) != '0) rv[k] = 1'b0;
                end
                cycle($urandom_range(0, 9) < 8, rv, $urandom_range(0, 499) == 0);
            end
            repeat (10) cycle(1, rv, 0);
        end

        repeat (3) cycle(0, ALL, 0);
        @(posedge clk);
        #2;
        chk("queue_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
